// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard/stall/forwarding signals of hazard_ctrl.
// Counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
    logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W;
    logic       mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E, dmem_req_M, dmem_ack_M;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout;
    logic [1:0] fwd_a_E, fwd_b_E, state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif
    modport master (
        output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W,
               mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E, dmem_req_M, dmem_ack_M,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout,
               fwd_a_E, fwd_b_E, state_o
`ifdef HAZARD_PERF_CNT_EN
        , input lu_stall_cnt, mem_stall_cnt, flush_cnt
`endif
    );
    modport slave (
        input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W,
               mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E, dmem_req_M, dmem_ack_M,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout,
               fwd_a_E, fwd_b_E, state_o
`ifdef HAZARD_PERF_CNT_EN
        , output lu_stall_cnt, mem_stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RV32 pipeline.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT      = 64,
    parameter int REDIRECT_BUBBLES = 0
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int RW = (REDIRECT_BUBBLES > 0) ? $clog2(REDIRECT_BUBBLES + 1) : 1;
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_cnt_nx;
    logic [RW-1:0] redir_cnt, redir_cnt_nx;
    logic          to_reg, to_now, lu, mw, stall_all, stall_fd, fl_d, fl_e;
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                           input logic ww, input logic [4:0] rw);
        return (wm && rm != 5'd0 && rm == rs) ? 2'b10 : (ww && rw != 5'd0 && rw == rs) ? 2'b01 : 2'b00;
    endfunction
    assign lu = hz.mem_rd_E && hz.rd_E != 5'd0 && (hz.rd_E == hz.rs1_addr_D || hz.rd_E == hz.rs2_addr_D);
    assign mw = hz.dmem_req_M && !hz.dmem_ack_M;
    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        redir_cnt_nx = redir_cnt;
        stall_all    = 1'b0;
        stall_fd     = 1'b0;
        fl_d         = 1'b0;
        fl_e         = 1'b0;
        to_now       = 1'b0;
        case (state)
            RUN: begin
                if (mw) begin
                    stall_all   = 1'b1;
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = WW'(1);
                end else if (hz.br_taken_E) begin
                    fl_d = 1'b1;
                    fl_e = 1'b1;
                    if (REDIRECT_BUBBLES > 0) begin
                        state_nx     = REDIRECT;
                        redir_cnt_nx = RW'(REDIRECT_BUBBLES);
                    end
                end else if (lu) begin
                    stall_fd = 1'b1;
                    fl_e     = 1'b1;
                end
            end
            MEM_WAIT: begin
                // a held br_taken_E is simply ignored here and picked up again in RUN
                if (hz.dmem_ack_M) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (MEM_TIMEOUT != 0 && wait_cnt == WW'(MEM_TIMEOUT)) begin
                    to_now      = 1'b1;
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else begin
                    stall_all   = 1'b1;
                    wait_cnt_nx = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
                end
            end
            REDIRECT: begin
                if (mw) begin
                    stall_all    = 1'b1;
                    state_nx     = MEM_WAIT;
                    wait_cnt_nx  = WW'(1);
                    redir_cnt_nx = '0;
                end else begin
                    fl_d         = 1'b1;
                    redir_cnt_nx = redir_cnt - 1'b1;
                    state_nx     = (redir_cnt <= RW'(1)) ? RUN : REDIRECT;
                end
            end
            default: state_nx = RUN;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            redir_cnt <= '0;
            to_reg    <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            redir_cnt <= redir_cnt_nx;
            to_reg    <= to_reg | to_now;
        end
    end
    // outputs are forced quiet while reset is held, regardless of inputs
    assign hz.stall_F     = !reset && (stall_all || stall_fd);
    assign hz.stall_D     = !reset && (stall_all || stall_fd);
    assign hz.stall_E     = !reset && stall_all;
    assign hz.stall_M     = !reset && stall_all;
    assign hz.flush_D     = !reset && fl_d;
    assign hz.flush_E     = !reset && fl_e;
    assign hz.fwd_a_E     = reset ? 2'b00 : fwd_sel(hz.rs1_addr_E, hz.reg_wr_M, hz.rd_M, hz.reg_wr_W, hz.rd_W);
    assign hz.fwd_b_E     = reset ? 2'b00 : fwd_sel(hz.rs2_addr_E, hz.reg_wr_M, hz.rd_M, hz.reg_wr_W, hz.rd_W);
    assign hz.mem_timeout = to_reg | to_now;
    assign hz.state_o     = state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_q, mem_q, fl_q;
    logic        lu_inc;
    assign lu_inc = !reset && state == RUN && !mw && !hz.br_taken_E && lu;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_q  <= '0;
            mem_q <= '0;
            fl_q  <= '0;
        end else begin
            lu_q  <= lu_q + {31'd0, lu_inc && !(&lu_q)};
            mem_q <= mem_q + {31'd0, hz.stall_M && !(&mem_q)};
            fl_q  <= fl_q + {31'd0, (hz.flush_D || hz.flush_E) && !(&fl_q)};
        end
    end
    assign hz.lu_stall_cnt  = lu_q;
    assign hz.mem_stall_cnt = mem_q;
    assign hz.flush_cnt     = fl_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, REDIRECT_BUBBLES=2).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    hazard_ctrl_if hz();
    hazard_ctrl #(.MEM_TIMEOUT(4), .REDIRECT_BUBBLES(2)) dut (.clk(clk), .reset(reset), .hz(hz.slave));
    typedef struct {string name; logic [12:0] v;} exp_t;
    exp_t q[$];
    exp_t cur;
    int total = 0;
    int bad = 0;
    logic [12:0] got;
    // {stall_F,stall_D,stall_E,stall_M, flush_D,flush_E, fwd_a, fwd_b, mem_timeout, state}
    function automatic logic [12:0] mk(input logic [3:0] s, input logic [1:0] f, input logic [1:0] a,
                                       input logic [1:0] b, input logic t, input logic [1:0] st);
        return {s, f, a, b, t, st};
    endfunction
    task automatic idle();
        hz.rs1_addr_D = 0; hz.rs2_addr_D = 0; hz.rs1_addr_E = 0; hz.rs2_addr_E = 0;
        hz.rd_E = 0; hz.rd_M = 0; hz.rd_W = 0; hz.mem_rd_E = 0; hz.reg_wr_M = 0; hz.reg_wr_W = 0;
        hz.br_taken_E = 0; hz.dmem_req_M = 0; hz.dmem_ack_M = 0;
    endtask
    task automatic step(input string n, input logic [12:0] e);
        q.push_back('{n, e});
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            got = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.flush_D, hz.flush_E,
                   hz.fwd_a_E, hz.fwd_b_E, hz.mem_timeout, hz.state_o};
            total++;
            if (got !== cur.v) begin
                bad++;
                $display("FAIL %s got=%b expected=%b", cur.name, got, cur.v);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        idle();
        @(posedge clk);
        #1;
        hz.dmem_req_M = 1; hz.rs1_addr_E = 7; hz.rd_M = 7; hz.reg_wr_M = 1; hz.br_taken_E = 1;
        step("rst_hold", mk(0, 0, 0, 0, 0, 0));
        reset = 0; idle();
        step("idle", mk(0, 0, 0, 0, 0, 0));
        // load-use
        idle(); hz.mem_rd_E = 1; hz.rd_E = 5; hz.rs2_addr_D = 5;
        step("lu_rs2", mk(4'b1100, 2'b01, 0, 0, 0, 0));
        idle();
        step("lu_next", mk(0, 0, 0, 0, 0, 0));
        idle(); hz.mem_rd_E = 1; hz.rd_E = 5; hz.rs1_addr_D = 5;
        step("lu_rs1", mk(4'b1100, 2'b01, 0, 0, 0, 0));
        idle(); hz.mem_rd_E = 1; hz.rd_E = 0; hz.rs1_addr_D = 0;
        step("lu_x0", mk(0, 0, 0, 0, 0, 0));
        idle(); hz.rd_E = 5; hz.rs1_addr_D = 5;
        step("lu_noload", mk(0, 0, 0, 0, 0, 0));
        // forwarding
        idle(); hz.rs1_addr_E = 7; hz.rd_M = 7; hz.reg_wr_M = 1; hz.rd_W = 7; hz.reg_wr_W = 1;
        step("fwd_mem", mk(0, 0, 2'b10, 0, 0, 0));
        hz.reg_wr_M = 0;
        step("fwd_wb", mk(0, 0, 2'b01, 0, 0, 0));
        hz.rd_W = 0;
        step("fwd_none", mk(0, 0, 0, 0, 0, 0));
        idle(); hz.reg_wr_M = 1; hz.reg_wr_W = 1;
        step("fwd_x0", mk(0, 0, 0, 0, 0, 0));
        idle(); hz.rs1_addr_E = 4; hz.rs2_addr_E = 3; hz.rd_M = 3; hz.reg_wr_M = 1; hz.rd_W = 4; hz.reg_wr_W = 1;
        step("fwd_mix", mk(0, 0, 2'b01, 2'b10, 0, 0));
        // memory wait, ack after three stalled cycles
        idle(); hz.dmem_req_M = 1;
        step("mw_run", mk(4'hF, 0, 0, 0, 0, 0));
        step("mw_w1", mk(4'hF, 0, 0, 0, 0, 1));
        step("mw_w2", mk(4'hF, 0, 0, 0, 0, 1));
        hz.dmem_ack_M = 1;
        step("mw_ack", mk(0, 0, 0, 0, 0, 1));
        idle();
        step("mw_done", mk(0, 0, 0, 0, 0, 0));
        // branch held through a memory wait is deferred, then redirects
        idle(); hz.dmem_req_M = 1; hz.br_taken_E = 1;
        step("df_run", mk(4'hF, 0, 0, 0, 0, 0));
        step("df_w1", mk(4'hF, 0, 0, 0, 0, 1));
        hz.dmem_ack_M = 1;
        step("df_ack", mk(0, 0, 0, 0, 0, 1));
        idle(); hz.br_taken_E = 1;
        step("df_br", mk(0, 2'b11, 0, 0, 0, 0));
        idle();
        step("df_r2", mk(0, 2'b10, 0, 0, 0, 2));
        step("df_r1", mk(0, 2'b10, 0, 0, 0, 2));
        step("df_end", mk(0, 0, 0, 0, 0, 0));
        // memory wait interrupting a redirect discards remaining bubbles
        idle(); hz.br_taken_E = 1;
        step("rm_br", mk(0, 2'b11, 0, 0, 0, 0));
        idle(); hz.dmem_req_M = 1;
        step("rm_mw", mk(4'hF, 0, 0, 0, 0, 2));
        hz.dmem_ack_M = 1;
        step("rm_ack", mk(0, 0, 0, 0, 0, 1));
        idle();
        step("rm_end", mk(0, 0, 0, 0, 0, 0));
        // timeout after four MEM_WAIT cycles without ack
        idle(); hz.dmem_req_M = 1;
        step("to_run", mk(4'hF, 0, 0, 0, 0, 0));
        step("to_w1", mk(4'hF, 0, 0, 0, 0, 1));
        step("to_w2", mk(4'hF, 0, 0, 0, 0, 1));
        step("to_w3", mk(4'hF, 0, 0, 0, 0, 1));
        step("to_w4", mk(0, 0, 0, 0, 1, 1));
        idle();
        step("to_rel", mk(0, 0, 0, 0, 1, 0));
        step("to_sticky", mk(0, 0, 0, 0, 1, 0));
        // redirect with a simultaneous load-use that must be suppressed
        idle(); hz.br_taken_E = 1; hz.mem_rd_E = 1; hz.rd_E = 5; hz.rs1_addr_D = 5;
        step("br_lu", mk(0, 2'b11, 0, 0, 1, 0));
        hz.br_taken_E = 0;
        step("br_r2", mk(0, 2'b10, 0, 0, 1, 2));
        step("br_r1", mk(0, 2'b10, 0, 0, 1, 2));
        idle();
        step("br_end", mk(0, 0, 0, 0, 1, 0));
        // asynchronous reset in the middle of a redirect
        idle(); hz.br_taken_E = 1;
        step("br2", mk(0, 2'b11, 0, 0, 1, 0));
        idle(); hz.mem_rd_E = 1; hz.rd_E = 5; hz.rs1_addr_D = 5; hz.rs1_addr_E = 7; hz.rd_M = 7; hz.reg_wr_M = 1;
        reset = 1;
        step("rst_async", mk(0, 0, 0, 0, 0, 0));
        reset = 0; idle();
        step("rst_after", mk(0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
